// File: rtl/control_seq.sv
// Microcoded-style control sequencer for an 8-bit accumulator CPU: decodes
// fetch/execute step, opcode and flags into one cycle's worth of datapath strobes.
module control_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       flag_c,
    input  logic       flag_z,
    output logic       c_pc_inc,
    output logic       c_pc_load,
    output logic       c_pc_out,
    output logic       c_mar_load,
    output logic       c_ram_out,
    output logic       c_ram_in,
    output logic       c_ir_load,
    output logic       c_ir_out,
    output logic       c_a_load,
    output logic       c_a_out,
    output logic       c_b_load,
    output logic       c_alu_out,
    output logic       c_alu_sub,
    output logic       c_flags_load,
    output logic       c_out_load,
    output logic       halted
);

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        HALT = 3'd5
    } step_t;

    typedef struct packed {
        logic pc_inc;
        logic pc_load;
        logic pc_out;
        logic mar_load;
        logic ram_out;
        logic ram_in;
        logic ir_load;
        logic ir_out;
        logic a_load;
        logic a_out;
        logic b_load;
        logic alu_out;
        logic alu_sub;
        logic flags_load;
        logic out_load;
        logic halted;
    } ctl_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    step_t step, step_nxt;
    ctl_t  ctl, ctl_gated;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) step <= T0;
        else        step <= step_nxt;
    end

    always_comb begin
        step_nxt = step;
        ctl      = '0;
        case (step)
            T0: begin
                ctl.pc_out   = 1'b1;
                ctl.mar_load = 1'b1;
                step_nxt     = T1;
            end
            T1: begin
                ctl.ram_out = 1'b1;
                ctl.ir_load = 1'b1;
                ctl.pc_inc  = 1'b1;
                step_nxt    = T2;
            end
            T2: begin
                step_nxt = T0;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctl.ir_out   = 1'b1;
                        ctl.mar_load = 1'b1;
                        step_nxt     = T3;
                    end
                    OP_LDI: begin
                        ctl.ir_out = 1'b1;
                        ctl.a_load = 1'b1;
                    end
                    OP_JMP: begin
                        ctl.ir_out  = 1'b1;
                        ctl.pc_load = 1'b1;
                    end
                    // Conditional jumps still put the target on the bus; only the load is gated.
                    OP_JC: begin
                        ctl.ir_out  = 1'b1;
                        ctl.pc_load = flag_c;
                    end
                    OP_JZ: begin
                        ctl.ir_out  = 1'b1;
                        ctl.pc_load = flag_z;
                    end
                    OP_OUT: begin
                        ctl.a_out    = 1'b1;
                        ctl.out_load = 1'b1;
                    end
                    OP_HLT:  step_nxt = HALT;
                    default: step_nxt = T0;
                endcase
            end
            T3: begin
                step_nxt = T0;
                case (opcode)
                    OP_LDA: begin
                        ctl.ram_out = 1'b1;
                        ctl.a_load  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctl.ram_out = 1'b1;
                        ctl.b_load  = 1'b1;
                        step_nxt    = T4;
                    end
                    OP_STA: begin
                        ctl.a_out  = 1'b1;
                        ctl.ram_in = 1'b1;
                    end
                    default: step_nxt = T0;
                endcase
            end
            T4: begin
                ctl.alu_out    = 1'b1;
                ctl.a_load     = 1'b1;
                ctl.flags_load = 1'b1;
                ctl.alu_sub    = (opcode == OP_SUB);
                step_nxt       = T0;
            end
            HALT: begin
                ctl.halted = 1'b1;
                step_nxt   = HALT;
            end
            default: step_nxt = T0;
        endcase
    end

    // Gate with reset combinationally so strobes drop the instant reset asserts,
    // not at the next edge.
    assign ctl_gated = reset ? ctl : '0;

    assign c_pc_inc     = ctl_gated.pc_inc;
    assign c_pc_load    = ctl_gated.pc_load;
    assign c_pc_out     = ctl_gated.pc_out;
    assign c_mar_load   = ctl_gated.mar_load;
    assign c_ram_out    = ctl_gated.ram_out;
    assign c_ram_in     = ctl_gated.ram_in;
    assign c_ir_load    = ctl_gated.ir_load;
    assign c_ir_out     = ctl_gated.ir_out;
    assign c_a_load     = ctl_gated.a_load;
    assign c_a_out      = ctl_gated.a_out;
    assign c_b_load     = ctl_gated.b_load;
    assign c_alu_out    = ctl_gated.alu_out;
    assign c_alu_sub    = ctl_gated.alu_sub;
    assign c_flags_load = ctl_gated.flags_load;
    assign c_out_load   = ctl_gated.out_load;
    assign halted       = ctl_gated.halted;

endmodule

// File: tb/tb_control_seq.sv
// Bench for control_seq: per-opcode step tables fed through a scoreboard queue,
// plus hand-written halt and mid-instruction reset sequences.
module tb_control_seq;

    localparam logic [15:0] PC_INC   = 16'h8000;
    localparam logic [15:0] PC_LOAD  = 16'h4000;
    localparam logic [15:0] PC_OUT   = 16'h2000;
    localparam logic [15:0] MAR_LD   = 16'h1000;
    localparam logic [15:0] RAM_OUT  = 16'h0800;
    localparam logic [15:0] RAM_IN   = 16'h0400;
    localparam logic [15:0] IR_LD    = 16'h0200;
    localparam logic [15:0] IR_OUT   = 16'h0100;
    localparam logic [15:0] A_LD     = 16'h0080;
    localparam logic [15:0] A_OUT    = 16'h0040;
    localparam logic [15:0] B_LD     = 16'h0020;
    localparam logic [15:0] ALU_OUT  = 16'h0010;
    localparam logic [15:0] ALU_SUB  = 16'h0008;
    localparam logic [15:0] FLAGS_LD = 16'h0004;
    localparam logic [15:0] OUT_LD   = 16'h0002;
    localparam logic [15:0] HALTED   = 16'h0001;
    localparam logic [15:0] BUS_DRV  = PC_OUT | RAM_OUT | IR_OUT | A_OUT | ALU_OUT;
    localparam logic [15:0] W_T0     = PC_OUT | MAR_LD;
    localparam logic [15:0] W_T1     = RAM_OUT | IR_LD | PC_INC;

    logic       clk, reset, flag_c, flag_z;
    logic [3:0] opcode;
    logic c_pc_inc, c_pc_load, c_pc_out, c_mar_load, c_ram_out, c_ram_in, c_ir_load, c_ir_out;
    logic c_a_load, c_a_out, c_b_load, c_alu_out, c_alu_sub, c_flags_load, c_out_load, halted;
    logic [15:0] act;

    typedef struct {
        logic [3:0]  op;
        logic        fc;
        logic        fz;
        int          n;
        logic [15:0] w2, w3, w4;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] sb_q[$];
    string       nm_q[$];
    int          nerr = 0;
    int          nchk = 0;

    control_seq dut (
        .clk(clk), .reset(reset), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .c_pc_inc(c_pc_inc), .c_pc_load(c_pc_load), .c_pc_out(c_pc_out),
        .c_mar_load(c_mar_load), .c_ram_out(c_ram_out), .c_ram_in(c_ram_in),
        .c_ir_load(c_ir_load), .c_ir_out(c_ir_out), .c_a_load(c_a_load),
        .c_a_out(c_a_out), .c_b_load(c_b_load), .c_alu_out(c_alu_out),
        .c_alu_sub(c_alu_sub), .c_flags_load(c_flags_load), .c_out_load(c_out_load),
        .halted(halted)
    );

    assign act = {c_pc_inc, c_pc_load, c_pc_out, c_mar_load, c_ram_out, c_ram_in,
                  c_ir_load, c_ir_out, c_a_load, c_a_out, c_b_load, c_alu_out,
                  c_alu_sub, c_flags_load, c_out_load, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", nerr);
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic [3:0] op, input logic fc, input logic fz,
                                input int n, input logic [15:0] w2, input logic [15:0] w3,
                                input logic [15:0] w4);
        vec_t v;
        v.op = op; v.fc = fc; v.fz = fz; v.n = n; v.w2 = w2; v.w3 = w3; v.w4 = w4;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
        nchk++;
        if ($countones(act & BUS_DRV) > 1 || (act[15] && act[14])) begin
            nerr++;
            $display("FAIL %s_excl: got %h want <=1 bus driver and no pc_inc&pc_load", name, act);
        end
    endtask

    task automatic push(input string name, input logic [15:0] w);
        sb_q.push_back(w);
        nm_q.push_back(name);
    endtask

    // One expected word per cycle; checked just after the falling edge.
    task automatic drain();
        logic [15:0] w;
        string       nm;
        while (sb_q.size() > 0) begin
            w  = sb_q.pop_front();
            nm = nm_q.pop_front();
            #1 chk(nm, w);
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v);
        opcode = v.op; flag_c = v.fc; flag_z = v.fz;
        push($sformatf("op%h_T0", v.op), W_T0);
        push($sformatf("op%h_T1", v.op), W_T1);
        push($sformatf("op%h_c%0dz%0d_T2", v.op, v.fc, v.fz), v.w2);
        if (v.n > 3) push($sformatf("op%h_T3", v.op), v.w3);
        if (v.n > 4) push($sformatf("op%h_T4", v.op), v.w4);
        drain();
    endtask

    initial begin
        add(4'h5, 0, 0, 3, IR_OUT | A_LD, 0, 0);
        add(4'h1, 0, 0, 4, IR_OUT | MAR_LD, RAM_OUT | A_LD, 0);
        add(4'h2, 0, 0, 5, IR_OUT | MAR_LD, RAM_OUT | B_LD, ALU_OUT | A_LD | FLAGS_LD);
        add(4'h3, 0, 0, 5, IR_OUT | MAR_LD, RAM_OUT | B_LD, ALU_OUT | A_LD | FLAGS_LD | ALU_SUB);
        add(4'h4, 0, 0, 4, IR_OUT | MAR_LD, A_OUT | RAM_IN, 0);
        add(4'h6, 0, 0, 3, IR_OUT | PC_LOAD, 0, 0);
        add(4'h7, 1, 0, 3, IR_OUT | PC_LOAD, 0, 0);
        add(4'h7, 0, 1, 3, IR_OUT, 0, 0);
        add(4'h8, 0, 1, 3, IR_OUT | PC_LOAD, 0, 0);
        add(4'h8, 1, 0, 3, IR_OUT, 0, 0);
        add(4'hE, 0, 0, 3, A_OUT | OUT_LD, 0, 0);
        add(4'h0, 1, 1, 3, 0, 0, 0);
        for (int k = 9; k <= 13; k++) add(k[3:0], 1, 1, 3, 0, 0, 0);
        add(4'h3, 1, 1, 5, IR_OUT | MAR_LD, RAM_OUT | B_LD, ALU_OUT | A_LD | FLAGS_LD | ALU_SUB);

        // Reset held from time zero: everything must stay low across clock edges.
        reset = 1'b0; opcode = 4'h5; flag_c = 1'b0; flag_z = 1'b0;
        #2 chk("reset_t0", 16'h0000);
        repeat (3) @(posedge clk);
        #1 chk("reset_hold", 16'h0000);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // HLT: halted from the cycle after T2, stuck there until reset.
        opcode = 4'hF; flag_c = 1'b1; flag_z = 1'b1;
        push("hlt_T0", W_T0);
        push("hlt_T1", W_T1);
        push("hlt_T2", 16'h0000);
        for (int k = 0; k < 20; k++) push($sformatf("hlt_halt%0d", k), HALTED);
        drain();
        #2 reset = 1'b0;
        #1 chk("hlt_reset_async", 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        run_vec(tbl[0]);

        // Reset asserted between edges while sitting in T3 of an ADD.
        opcode = 4'h2; flag_c = 1'b0; flag_z = 1'b0;
        push("add_T0", W_T0);
        push("add_T1", W_T1);
        push("add_T2", IR_OUT | MAR_LD);
        drain();
        #1 chk("add_T3_pre", RAM_OUT | B_LD);
        #2 reset = 1'b0;
        #1 chk("add_reset_async", 16'h0000);
        @(posedge clk);
        #1 chk("add_reset_hold", 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        run_vec(tbl[0]);
        run_vec(tbl[2]);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
